// File: rtl/hazard_sched_if.sv
// ID-stage instruction fields, EX branch outcome and the hazard controls returned to the pipeline.
// master = pipeline side, slave = hazard_sched.
interface hazard_sched_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       id_rd;
   logic             id_regwrite;
   logic             id_memread;
   logic             ex_taken;
   logic             stall_f;
   logic             stall_d;
   logic             flush_d;
   logic             flush_e;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread, ex_taken,
      input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread, ex_taken,
      output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, stall_cnt
   );
endinterface

// File: rtl/hazard_sched.sv
// Stall/flush/forwarding control for a 5-stage RV32I pipeline, scoreboarding EX/MEM/WB destinations.
// Controls are combinational in the current cycle; a stall holds PC and IF/ID until the hazard clears.
module hazard_sched #(
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic          clk,
   input  logic          reset,
   hazard_sched_if.slave hif
);
   typedef enum logic {RUN, STALL} state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
   } dst_t;

   typedef struct packed {
      dst_t       dst;
      logic       memread;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use_rs1;
      logic       use_rs2;
   } ex_entry_t;

   function automatic logic hits(dst_t e, logic [4:0] src, logic use_src);
      return e.valid && e.regwrite && (e.rd != 5'd0) && (e.rd == src) && use_src;
   endfunction

   // A load sitting in MEM has no data yet, so it may only forward once it reaches WB.
   function automatic logic [1:0] fwd_sel(dst_t mem_e, logic mem_ld, dst_t wb_e,
                                          logic [4:0] src, logic use_src);
      if (hits(mem_e, src, use_src) && !mem_ld) return 2'b10;
      else if (hits(wb_e, src, use_src))        return 2'b01;
      else                                      return 2'b00;
   endfunction

   state_t           state_q, state_d;
   ex_entry_t        ex_q, ex_d;
   dst_t             mem_q, mem_d;
   dst_t             wb_q, wb_d;
   logic             mem_load_q, mem_load_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       hit_ex, hit_mem, hit_wb;
   logic       hazard, stall, flush_e;
   logic [1:0] fwd_a, fwd_b;

   always_comb begin
      hit_ex  = hits(ex_q.dst, hif.id_rs1, hif.id_use_rs1) || hits(ex_q.dst, hif.id_rs2, hif.id_use_rs2);
      hit_mem = hits(mem_q,    hif.id_rs1, hif.id_use_rs1) || hits(mem_q,    hif.id_rs2, hif.id_use_rs2);
      hit_wb  = hits(wb_q,     hif.id_rs1, hif.id_use_rs1) || hits(wb_q,     hif.id_rs2, hif.id_use_rs2);

      if (FWD_EN) hazard = hif.id_valid && ex_q.memread && hit_ex;
      else        hazard = hif.id_valid && (hit_ex || hit_mem || hit_wb);

      // A taken branch kills the stalled instruction anyway, so it wins.
      stall   = hazard && !hif.ex_taken;
      flush_e = hazard || hif.ex_taken;

      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_EN && ex_q.dst.valid) begin
         fwd_a = fwd_sel(mem_q, mem_load_q, wb_q, ex_q.rs1, ex_q.use_rs1);
         fwd_b = fwd_sel(mem_q, mem_load_q, wb_q, ex_q.rs2, ex_q.use_rs2);
      end

      ex_d = '0;
      if (!flush_e && hif.id_valid) begin
         ex_d.dst.valid    = 1'b1;
         ex_d.dst.rd       = hif.id_rd;
         ex_d.dst.regwrite = hif.id_regwrite;
         ex_d.memread      = hif.id_memread;
         ex_d.rs1          = hif.id_rs1;
         ex_d.rs2          = hif.id_rs2;
         ex_d.use_rs1      = hif.id_use_rs1;
         ex_d.use_rs2      = hif.id_use_rs2;
      end
      mem_d      = ex_q.dst;
      mem_load_d = ex_q.memread;
      wb_d       = mem_q;

      state_d = state_q;
      case (state_q)
         RUN:     if (stall)  state_d = STALL;
         STALL:   if (!stall) state_d = RUN;
         default: state_d = RUN;
      endcase

      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         mem_load_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ex_q       <= ex_d;
         mem_q      <= mem_d;
         wb_q       <= wb_d;
         mem_load_q <= mem_load_d;
         cnt_q      <= cnt_d;
      end
   end

   assign hif.stall_f   = reset && stall;
   assign hif.stall_d   = reset && stall;
   assign hif.flush_d   = reset && hif.ex_taken;
   assign hif.flush_e   = reset && flush_e;
   assign hif.fwd_a     = reset ? fwd_a : 2'b00;
   assign hif.fwd_b     = reset ? fwd_b : 2'b00;
   assign hif.stall_cnt = reset ? cnt_q : '0;
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: forwarding instance (16-bit counter) and stall-only instance (2-bit counter).
module tb_hazard_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0;
   logic rst_b = 1'b0;

   hazard_sched_if #(.CNT_W(16)) if_a ();
   hazard_sched_if #(.CNT_W(2))  if_b ();

   hazard_sched #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd   (.clk(clk), .reset(rst_a), .hif(if_a));
   hazard_sched #(.FWD_EN(1'b0), .CNT_W(2))  u_nofwd (.clk(clk), .reset(rst_b), .hif(if_b));

   typedef struct {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } instr_t;

   typedef struct {
      bit          sel;
      logic [7:0]  ctl;
      logic [15:0] cnt;
      string       name;
   } exp_t;

   // ctl = {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b}
   localparam logic [7:0] C0    = 8'b0000_0000;
   localparam logic [7:0] STL   = 8'b1101_0000;
   localparam logic [7:0] TKN   = 8'b0011_0000;
   localparam logic [7:0] FA_WB = 8'b0000_0100;
   localparam logic [7:0] F_MEM = 8'b0000_1010;
   localparam logic [7:0] F_WB  = 8'b0000_0101;

   exp_t expq[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic instr_t nop();
      instr_t i;
      i.valid = 1'b0; i.rs1 = 5'd0; i.rs2 = 5'd0; i.u1 = 1'b0; i.u2 = 1'b0;
      i.rd = 5'd0; i.rw = 1'b0; i.mr = 1'b0;
      return i;
   endfunction

   function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      instr_t i;
      i.valid = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1;
      i.rd = rd; i.rw = 1'b1; i.mr = 1'b0;
      return i;
   endfunction

   function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
      instr_t i;
      i.valid = 1'b1; i.rs1 = rs1; i.rs2 = 5'd0; i.u1 = 1'b1; i.u2 = 1'b0;
      i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
      return i;
   endfunction

   task automatic issue(input bit sel, input instr_t ins, input logic taken, input logic rstv,
                        input logic [7:0] ctl, input logic [15:0] cnt, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      if (!sel) begin
         if_a.id_valid = ins.valid; if_a.id_rs1 = ins.rs1; if_a.id_rs2 = ins.rs2;
         if_a.id_use_rs1 = ins.u1; if_a.id_use_rs2 = ins.u2; if_a.id_rd = ins.rd;
         if_a.id_regwrite = ins.rw; if_a.id_memread = ins.mr; if_a.ex_taken = taken;
         rst_a = rstv;
      end else begin
         if_b.id_valid = ins.valid; if_b.id_rs1 = ins.rs1; if_b.id_rs2 = ins.rs2;
         if_b.id_use_rs1 = ins.u1; if_b.id_use_rs2 = ins.u2; if_b.id_rd = ins.rd;
         if_b.id_regwrite = ins.rw; if_b.id_memread = ins.mr; if_b.ex_taken = taken;
         rst_b = rstv;
      end
      e.sel = sel; e.ctl = ctl; e.cnt = cnt; e.name = name;
      expq.push_back(e);
   endtask

   // Monitor: compare every presented cycle against the oldest expectation.
   exp_t        m_e;
   logic [7:0]  act_ctl;
   logic [15:0] act_cnt;
   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            m_e = expq.pop_front();
            if (!m_e.sel) begin
               act_ctl = {if_a.stall_f, if_a.stall_d, if_a.flush_d, if_a.flush_e, if_a.fwd_a, if_a.fwd_b};
               act_cnt = if_a.stall_cnt;
            end else begin
               act_ctl = {if_b.stall_f, if_b.stall_d, if_b.flush_d, if_b.flush_e, if_b.fwd_a, if_b.fwd_b};
               act_cnt = {14'd0, if_b.stall_cnt};
            end
            checks++;
            if (act_ctl !== m_e.ctl) begin
               failures++;
               $display("FAIL %s ctl: got %b expected %b", m_e.name, act_ctl, m_e.ctl);
            end
            checks++;
            if (act_cnt !== m_e.cnt) begin
               failures++;
               $display("FAIL %s stall_cnt: got %0d expected %0d", m_e.name, act_cnt, m_e.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.id_valid = 0; if_a.id_rs1 = 0; if_a.id_rs2 = 0; if_a.id_use_rs1 = 0; if_a.id_use_rs2 = 0;
      if_a.id_rd = 0; if_a.id_regwrite = 0; if_a.id_memread = 0; if_a.ex_taken = 0;
      if_b.id_valid = 0; if_b.id_rs1 = 0; if_b.id_rs2 = 0; if_b.id_use_rs1 = 0; if_b.id_use_rs2 = 0;
      if_b.id_rd = 0; if_b.id_regwrite = 0; if_b.id_memread = 0; if_b.ex_taken = 0;

      // Reset forces zeros even with a taken branch presented
      issue(0, alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, C0, 16'd0, "reset_outputs_zero");

      // 1: load-use stall, then WB forward
      issue(0, lw(5'd5, 5'd1),            1'b0, 1'b1, C0,    16'd0, "t1_lw_issue");
      issue(0, alu(5'd6, 5'd5, 5'd2),     1'b0, 1'b1, STL,   16'd0, "t1_loaduse_stall");
      issue(0, alu(5'd6, 5'd5, 5'd2),     1'b0, 1'b1, C0,    16'd1, "t1_stall_one_cycle");
      issue(0, nop(),                     1'b0, 1'b1, FA_WB, 16'd1, "t1_fwd_a_wb");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t1_drain0");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t1_drain1");

      // 2: back-to-back dependency forwards from MEM; with a NOP gap from WB
      issue(0, alu(5'd3, 5'd1, 5'd2),     1'b0, 1'b1, C0,    16'd1, "t2_producer");
      issue(0, alu(5'd4, 5'd3, 5'd3),     1'b0, 1'b1, C0,    16'd1, "t2_no_stall");
      issue(0, nop(),                     1'b0, 1'b1, F_MEM, 16'd1, "t2_fwd_mem");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t2_drain0");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t2_drain1");
      issue(0, alu(5'd3, 5'd1, 5'd2),     1'b0, 1'b1, C0,    16'd1, "t2b_producer");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t2b_gap");
      issue(0, alu(5'd4, 5'd3, 5'd3),     1'b0, 1'b1, C0,    16'd1, "t2b_no_stall");
      issue(0, nop(),                     1'b0, 1'b1, F_WB,  16'd1, "t2b_fwd_wb");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t2b_drain0");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t2b_drain1");

      // 3: x0 never hits
      issue(0, alu(5'd0, 5'd1, 5'd2),     1'b0, 1'b1, C0,    16'd1, "t3_write_x0");
      issue(0, alu(5'd7, 5'd0, 5'd0),     1'b0, 1'b1, C0,    16'd1, "t3_x0_no_stall");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t3_x0_no_fwd");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t3_drain0");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t3_drain1");

      // 4: taken branch overrides a load-use stall
      issue(0, lw(5'd5, 5'd1),            1'b0, 1'b1, C0,    16'd1, "t4_lw_issue");
      issue(0, alu(5'd6, 5'd5, 5'd2),     1'b1, 1'b1, TKN,   16'd1, "t4_taken_over_stall");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t4_cnt_unchanged");
      issue(0, nop(),                     1'b0, 1'b1, C0,    16'd1, "t4_drain");

      // 5: no forwarding, RAW held 3 cycles (2-bit counter reaches all-ones)
      issue(1, alu(5'd3, 5'd1, 5'd2),     1'b0, 1'b1, C0,    16'd0, "t5_producer");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, STL,   16'd0, "t5_stall_ex");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, STL,   16'd1, "t5_stall_mem");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, STL,   16'd2, "t5_stall_wb");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, C0,    16'd3, "t5_release");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd3, "t5_no_fwd");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd3, "t5_drain0");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd3, "t5_drain1");

      // Counter saturation
      issue(1, alu(5'd3, 5'd1, 5'd2),     1'b0, 1'b1, C0,    16'd3, "sat_producer");
      for (int k = 0; k < 3; k++)
         issue(1, alu(5'd4, 5'd3, 5'd1),  1'b0, 1'b1, STL,   16'd3, "sat_stall_hold");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, C0,    16'd3, "sat_release");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd3, "sat_drain0");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd3, "sat_drain1");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd3, "sat_drain2");

      // 6: reset in the middle of a RAW stall
      issue(1, alu(5'd3, 5'd1, 5'd2),     1'b0, 1'b1, C0,    16'd3, "t6_producer");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, STL,   16'd3, "t6_stall");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b0, C0,    16'd0, "t6_reset_zero");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b1, 1'b0, C0,    16'd0, "t6_reset_taken_zero");
      issue(1, alu(5'd4, 5'd3, 5'd1),     1'b0, 1'b1, C0,    16'd0, "t6_after_release");
      issue(1, nop(),                     1'b0, 1'b1, C0,    16'd0, "t6_cnt_zero");

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: got %0d pending expected 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
